// File: rtl/multibank_saturator.sv
// multibank_saturator
//
// Two-stage streaming rescaler. Each accepted sample is right-shifted by a
// bank-selected amount (with optional round-half-up), clamped into OUT_W
// signed bits, and optionally converted to offset binary. Samples flagged
// with an upstream error are forced to midscale and never count as clipped.
// A 16-bit saturating counter tracks how many good samples were clipped.
//
// Ports
//   clk               single clock
//   reset_n           asynchronous active-low reset
//   sel               bank select, sampled only on ast_sink_valid cycles
//   ast_sink_data     signed input sample (IN_W bits)
//   ast_sink_valid    input sample strobe, no backpressure
//   ast_sink_error    upstream error, travels with its sample
//   clip_clear        synchronous clear of clip_count, wins over a clip
//   ast_source_data   scaled and saturated sample (OUT_W bits)
//   ast_source_valid  output strobe, two cycles after the input strobe
//   ast_source_error  error forwarded alongside its sample
//   clip_count        saturating count of clipped samples

module multibank_saturator #(
    parameter int                 IN_W       = 35,
    parameter int                 OUT_W      = 12,
    parameter int                 BANKS      = 4,
    parameter int                 SEL_W      = 2,
    parameter logic [8*BANKS-1:0] SHIFTS     = {8'd23, 8'd22, 8'd21, 8'd20},
    parameter int                 ROUND      = 1,
    parameter int                 OFFSET_BIN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEL_W-1:0] sel,
    input  logic [IN_W-1:0]  ast_sink_data,
    input  logic             ast_sink_valid,
    input  logic [1:0]       ast_sink_error,
    input  logic             clip_clear,
    output logic [OUT_W-1:0] ast_source_data,
    output logic             ast_source_valid,
    output logic [1:0]       ast_source_error,
    output logic [15:0]      clip_count
);

    // Stage-1 arithmetic is one bit wider than the input so that adding the
    // rounding bias to the most positive sample cannot overflow.
    localparam int SW = IN_W + 1;

    localparam logic [SEL_W:0]       BANKS_LIM = (SEL_W + 1)'(BANKS);
    localparam logic [SEL_W-1:0]     LAST_BANK = SEL_W'(BANKS - 1);
    localparam logic [7:0]           IN_W_U8   = 8'(IN_W);
    localparam logic signed [SW-1:0] ONE       = SW'(1);

    localparam logic signed [SW-1:0] CLAMP_MAX = {{(SW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] CLAMP_MIN = {{(SW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // In offset binary the MSB flip mask and the midscale code are the same
    // word (100...0); in two's complement both are zero.
    localparam logic [OUT_W-1:0] MSB_FLIP = (OFFSET_BIN != 0) ? {1'b1, {(OUT_W - 1){1'b0}}} : '0;
    localparam logic [OUT_W-1:0] MIDSCALE = MSB_FLIP;

    logic [SEL_W-1:0]     bank_idx;
    logic [7:0]           shift_amt;
    logic signed [SW-1:0] din_ext;
    logic signed [SW-1:0] bias;
    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] s_next;

    logic                 valid_s1;
    logic signed [SW-1:0] s_s1;
    logic [1:0]           error_s1;

    logic                 over_hi;
    logic                 under_lo;
    logic signed [SW-1:0] clamped;
    logic [OUT_W-1:0]     out_word;
    logic                 clip_hit;

    // Out-of-range selects fall back to the last bank, then the shift for
    // that bank is pulled out of the packed SHIFTS table.
    always_comb begin
        bank_idx  = sel;
        shift_amt = 8'd0;
        if ({1'b0, sel} >= BANKS_LIM) begin
            bank_idx = LAST_BANK;
        end
        for (int b = 0; b < BANKS; b++) begin
            if (bank_idx == SEL_W'(b)) begin
                shift_amt = SHIFTS[8*b +: 8];
            end
        end
    end

    // Rounding adds half an output LSB before the arithmetic shift. Shifts
    // at or beyond the input width collapse to the sign extension, which the
    // shifter alone would not guarantee once the bias is added.
    always_comb begin
        din_ext = $signed({ast_sink_data[IN_W-1], ast_sink_data});
        bias    = '0;
        if (ROUND != 0 && shift_amt != 8'd0 && shift_amt < IN_W_U8) begin
            bias = ONE << (shift_amt - 8'd1);
        end
        biased = din_ext + bias;
        if (shift_amt >= IN_W_U8) begin
            s_next = {SW{ast_sink_data[IN_W-1]}};
        end else begin
            s_next = biased >>> shift_amt;
        end
    end

    // Stage 1 register: the scaled value and its error are captured only on
    // valid cycles, so later sel or data changes cannot touch this sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_s1 <= 1'b0;
            s_s1     <= '0;
            error_s1 <= 2'b00;
        end else begin
            valid_s1 <= ast_sink_valid;
            if (ast_sink_valid) begin
                s_s1     <= s_next;
                error_s1 <= ast_sink_error;
            end
        end
    end

    // Clamp to the OUT_W signed range, apply the output coding, and force
    // errored samples to midscale. Errored samples never register as clips.
    always_comb begin
        over_hi  = (s_s1 > CLAMP_MAX);
        under_lo = (s_s1 < CLAMP_MIN);
        clamped  = s_s1;
        if (over_hi) begin
            clamped = CLAMP_MAX;
        end else if (under_lo) begin
            clamped = CLAMP_MIN;
        end
        out_word = clamped[OUT_W-1:0] ^ MSB_FLIP;
        if (error_s1 != 2'b00) begin
            out_word = MIDSCALE;
        end
        clip_hit = valid_s1 && (over_hi || under_lo) && (error_s1 == 2'b00);
    end

    // Stage 2 register: data and error only move with a valid sample and
    // otherwise hold their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ast_source_valid <= 1'b0;
            ast_source_data  <= MIDSCALE;
            ast_source_error <= 2'b00;
        end else begin
            ast_source_valid <= valid_s1;
            if (valid_s1) begin
                ast_source_data  <= out_word;
                ast_source_error <= error_s1;
            end
        end
    end

    // The clip counter steps on the same edge that presents the clipped
    // sample, sticks at all-ones, and a clear on that edge takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_count <= 16'h0000;
        end else if (clip_clear) begin
            clip_count <= 16'h0000;
        end else if (clip_hit && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_multibank_saturator.sv
// tb_multibank_saturator
//
// Directed bench for multibank_saturator at default parameters. Each driven
// sample pushes its independently modelled result and due cycle onto a
// scoreboard; a negedge monitor pops and compares when the output strobe is
// due, and also flags any strobe that arrives when none is expected.

module tb_multibank_saturator;

    localparam int IN_W  = 35;
    localparam int OUT_W = 12;
    localparam int BANKS = 4;
    localparam int SEL_W = 2;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [1:0]       err;
        int               cycle;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [SEL_W-1:0] sel;
    logic [IN_W-1:0]  ast_sink_data;
    logic             ast_sink_valid;
    logic [1:0]       ast_sink_error;
    logic             clip_clear;
    logic [OUT_W-1:0] ast_source_data;
    logic             ast_source_valid;
    logic [1:0]       ast_source_error;
    logic [15:0]      clip_count;

    exp_t             sb[$];
    int               cycle;
    int               n_compared;
    int               n_failed;
    logic [15:0]      exp_count;
    logic [OUT_W-1:0] last_data;
    logic [1:0]       last_err;

    multibank_saturator dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sel              (sel),
        .ast_sink_data    (ast_sink_data),
        .ast_sink_valid   (ast_sink_valid),
        .ast_sink_error   (ast_sink_error),
        .clip_clear       (clip_clear),
        .ast_source_data  (ast_source_data),
        .ast_source_valid (ast_source_valid),
        .ast_source_error (ast_source_error),
        .clip_count       (clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: bank shifts are 20..23, round-half-up, clamp to 12 signed
    // bits, offset-binary output, midscale on error.
    function automatic logic [OUT_W-1:0] modelData(input longint d, input int selv,
                                                   input logic [1:0] err, output bit clipped);
        int     bank;
        int     sh;
        longint s;
        bank = (selv >= BANKS) ? BANKS - 1 : selv;
        sh   = 20 + bank;
        if (sh >= IN_W) s = (d < 0) ? -64'sd1 : 64'sd0;
        else            s = (d + (longint'(1) << (sh - 1))) >>> sh;
        clipped = ((s > 2047) || (s < -2048)) && (err == 2'b00);
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
        if (err != 2'b00) return 12'h800;
        return s[11:0] ^ 12'h800;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one sample for one cycle; when tracked, its modelled result is
    // due on the output two cycles after the capturing edge's predecessor.
    task automatic applyStimulus(input longint d, input int selv, input logic [1:0] err, input bit track);
        bit   clipped;
        exp_t e;
        @(negedge clk);
        ast_sink_data  = d[IN_W-1:0];
        sel            = selv[SEL_W-1:0];
        ast_sink_error = err;
        ast_sink_valid = 1'b1;
        if (track) begin
            e.data  = modelData(d, selv, err, clipped);
            e.err   = err;
            e.cycle = cycle + 2;
            sb.push_back(e);
            last_data = e.data;
            last_err  = err;
            if (clipped && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        ast_sink_valid = 1'b0;
        sel            = ~sel;
        ast_sink_data  = ~ast_sink_data;
    endtask

    task automatic clearPulse();
        @(negedge clk);
        ast_sink_valid = 1'b0;
        clip_clear     = 1'b1;
        @(negedge clk);
        clip_clear     = 1'b0;
    endtask

    task automatic drainAndCheck(input string tag);
        for (int i = 0; i < 16 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
        checkOutput({tag, "_clip_count"}, 32'(clip_count), 32'(exp_count));
        checkOutput({tag, "_hold_data"}, 32'(ast_source_data), 32'(last_data));
        checkOutput({tag, "_hold_err"}, 32'(ast_source_error), 32'(last_err));
    endtask

    // Output monitor: every negedge decides whether a strobe is due and
    // compares strobe, data and error against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_v;
        while (sb.size() != 0 && sb[0].cycle < cycle) void'(sb.pop_front());
        exp_v = (sb.size() != 0) && (sb[0].cycle == cycle);
        checkOutput("out_valid", 32'(ast_source_valid), 32'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            if (ast_source_valid) begin
                checkOutput("out_data", 32'(ast_source_data), 32'(e.data));
                checkOutput("out_err", 32'(ast_source_error), 32'(e.err));
            end
        end
    end

    initial begin
        longint      d;
        logic signed [IN_W-1:0] r;

        cycle          = 0;
        n_compared     = 0;
        n_failed       = 0;
        exp_count      = 16'd0;
        last_data      = 12'h800;
        last_err       = 2'b00;
        reset_n        = 1'b0;
        sel            = '0;
        ast_sink_data  = '0;
        ast_sink_valid = 1'b0;
        ast_sink_error = 2'b00;
        clip_clear     = 1'b0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(ast_source_valid), 32'd0);
        checkOutput("rst_data", 32'(ast_source_data), 32'h800);
        checkOutput("rst_err", 32'(ast_source_error), 32'd0);
        checkOutput("rst_count", 32'(clip_count), 32'd0);
        reset_n = 1'b1;

        $display("[TB] scaling and clipping");
        applyStimulus(longint'(1) << 20, 0, 2'b00, 1'b1);
        idleCycle();
        drainAndCheck("scale");
        applyStimulus((longint'(1) << 34) - 1, 0, 2'b00, 1'b1);
        idleCycle();
        drainAndCheck("pos_clip");
        applyStimulus(-(longint'(1) << 34), 0, 2'b00, 1'b1);
        idleCycle();
        drainAndCheck("neg_clip");

        $display("[TB] rounding edges");
        applyStimulus(longint'(1) << 19, 0, 2'b00, 1'b1);
        applyStimulus((longint'(1) << 19) - 1, 0, 2'b00, 1'b1);
        applyStimulus(-(longint'(1) << 19), 0, 2'b00, 1'b1);
        applyStimulus(-(longint'(1) << 19) - 1, 0, 2'b00, 1'b1);
        applyStimulus(longint'(2047) << 20, 0, 2'b00, 1'b1);
        applyStimulus(longint'(-2048) << 20, 0, 2'b00, 1'b1);
        idleCycle();
        drainAndCheck("round");

        $display("[TB] error forwarding and bank switching");
        applyStimulus((longint'(1) << 34) - 1, 0, 2'b01, 1'b1);
        idleCycle();
        drainAndCheck("error");
        applyStimulus(longint'(5) << 23, 3, 2'b00, 1'b1);
        applyStimulus(longint'(5) << 23, 0, 2'b00, 1'b1);
        applyStimulus(longint'(5) << 23, 2, 2'b10, 1'b1);
        applyStimulus(longint'(5) << 23, 2, 2'b00, 1'b1);
        applyStimulus(-(longint'(5) << 23), 1, 2'b00, 1'b1);
        idleCycle();
        drainAndCheck("banks");

        for (int i = 0; i < 24; i++) begin
            r = IN_W'({$urandom(), $urandom()});
            d = longint'(r) >>> $urandom_range(0, 14);
            applyStimulus(d, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, 1'b1);
        end
        idleCycle();
        drainAndCheck("random");

        $display("[TB] reset with samples in flight");
        applyStimulus((longint'(1) << 34) - 1, 0, 2'b00, 1'b0);
        applyStimulus(-(longint'(1) << 34), 1, 2'b00, 1'b0);
        #2;
        reset_n        = 1'b0;
        ast_sink_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_count", 32'(clip_count), 32'd0);
        checkOutput("midrst_data", 32'(ast_source_data), 32'h800);
        checkOutput("midrst_err", 32'(ast_source_error), 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        exp_count = 16'd0;
        last_data = 12'h800;
        last_err  = 2'b00;
        repeat (4) @(negedge clk);
        drainAndCheck("midrst");

        $display("[TB] clip counter saturation");
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(((i % 2) == 0) ? (longint'(1) << 34) - 1 : -(longint'(1) << 34),
                          int'($urandom_range(0, 3)), 2'b00, 1'b1);
        end
        idleCycle();
        drainAndCheck("saturate");

        $display("[TB] clear against concurrent clip");
        applyStimulus((longint'(1) << 34) - 1, 0, 2'b00, 1'b1);
        clearPulse();
        exp_count = 16'd0;
        drainAndCheck("clear_sat");
        applyStimulus(-(longint'(1) << 34), 2, 2'b00, 1'b1);
        clearPulse();
        exp_count = 16'd0;
        drainAndCheck("clear_zero");
        applyStimulus((longint'(1) << 34) - 1, 1, 2'b00, 1'b1);
        idleCycle();
        drainAndCheck("after_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/multibank_saturator.md
MULTIBANK_SATURATOR -- requirements
Module: multibank_saturator

Interface
REQ-001 The block SHALL have parameter IN_W, default 35, meaning the signed input sample width.
REQ-002 The block SHALL have parameter OUT_W, default 12, meaning the output sample width.
REQ-003 The block SHALL have parameter BANKS, default 4, meaning the number of selectable scaling banks.
REQ-004 The block SHALL have parameter SEL_W, default 2, meaning the bank-select width, with 2^SEL_W >= BANKS.
REQ-005 The block SHALL have parameter SHIFTS, default {8'd23,8'd22,8'd21,8'd20}, meaning a packed 8-bit right-shift per bank, with bank 0 in the LSBs.
REQ-006 The block SHALL have parameter ROUND, default 1, meaning round-half-up before truncation when 1 and plain truncation when 0.
REQ-007 The block SHALL have parameter OFFSET_BIN, default 1, meaning offset-binary output (MSB inverted) when 1 and two's complement when 0.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-009 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 The block SHALL have port sel, input, SEL_W bits: bank select.
REQ-011 The block SHALL have port ast_sink_data, input, IN_W bits: signed sample.
REQ-012 The block SHALL have port ast_sink_valid, input, 1 bit: sample strobe.
REQ-013 The block SHALL have port ast_sink_error, input, 2 bits: upstream error.
REQ-014 The block SHALL have port clip_clear, input, 1 bit: synchronous clear of clip_count.
REQ-015 The block SHALL have port ast_source_data, output, OUT_W bits: scaled and saturated sample.
REQ-016 The block SHALL have port ast_source_valid, output, 1 bit: output strobe.
REQ-017 The block SHALL have port ast_source_error, output, 2 bits: forwarded error.
REQ-018 The block SHALL have port clip_count, output, 16 bits: count of clipped samples.

Function
REQ-019 The pipeline SHALL have exactly 2 stages; ast_source_valid SHALL assert exactly 2 cycles after each ast_sink_valid cycle.
REQ-020 The pipeline SHALL have no backpressure and SHALL accept a new sample every cycle.
REQ-021 sel SHALL be captured only on ast_sink_valid cycles; a sel change between samples SHALL not affect samples already in flight.
REQ-022 If sel >= BANKS, the block SHALL use bank BANKS-1.
REQ-023 Stage 1 SHALL compute s = (ast_sink_data + bias) >>> shift at IN_W+1 bits with an arithmetic shift.
REQ-024 bias SHALL equal 2^(shift-1) when ROUND=1 and shift>0, and 0 otherwise.
REQ-025 If shift >= IN_W, stage 1 SHALL produce the sign extension of the input: 0 or -1.
REQ-026 Stage 2 SHALL clamp s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 When OFFSET_BIN=1, stage 2 SHALL invert the MSB of the clamped result.
REQ-028 A sample SHALL count as clipped when s lies outside the clamp range and its ast_sink_error == 0.
REQ-029 On each clipped sample, clip_count SHALL increment in the same cycle that ast_source_valid is asserted for that sample.
REQ-030 clip_count SHALL saturate at 16'hFFFF and SHALL not wrap.
REQ-031 When clip_clear coincides with a clip event, clip_count SHALL become 0; clear SHALL win.
REQ-032 If ast_sink_error != 0, the output data SHALL be forced to midscale (0 in two's complement, 2^(OUT_W-1) in offset binary).
REQ-033 The error value SHALL travel with its sample and appear on ast_source_error alongside it.
REQ-034 ast_source_data and ast_source_error SHALL hold their last value while ast_source_valid is 0.

Reset
REQ-035 While reset_n is low, all pipeline valids, ast_source_valid, ast_source_error and clip_count SHALL be 0.
REQ-036 While reset_n is low, ast_source_data SHALL be midscale.
REQ-037 Reset asserted mid-operation SHALL discard in-flight samples; no valid SHALL appear for them after release.
REQ-038 The first accepted sample after reset_n rises SHALL appear exactly 2 cycles later.

Verification
REQ-039 Scaling: bank 0 (shift 20), input 2^20, OFFSET_BIN=1 -> 0x801 two cycles later; clip_count stays 0.
REQ-040 Positive clip: bank 0, input 2^34-1 -> 0x7FF with OFFSET_BIN=0 or 0xFFF with OFFSET_BIN=1; clip_count = 1.
REQ-041 Negative clip: bank 0, input -2^34 -> 0x800 with OFFSET_BIN=0 or 0x000 with OFFSET_BIN=1; clip_count increments.
REQ-042 Rounding: bank 0, input 2^19 -> signed 1 with ROUND=1; signed 0 with ROUND=0.
REQ-043 Error and bank switch: clipping input with error 2'b01 -> output 0x800 (offset), error 01, no count; back-to-back samples on bank 3 then bank 0 -> each scaled by its own shift.
REQ-044 Reset and clear: reset pulsed with 2 samples in flight -> no output valids, clip_count 0; 65540 clipping samples -> clip_count 16'hFFFF; clip_clear with a concurrent clip -> 0.
